// File: rtl/mem_bus_arbiter_pkg.sv
//======================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types for the ibus/dbus to cbus memory arbiter.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    localparam int CBUS_ADDR_W = 64;
    localparam int CBUS_DATA_W = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        msize_t                 size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [7:0]             strobe;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Instruction words are 32 bits; bit 2 of the fetch address picks the half.
    function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] word);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_arb_grant.sv
//======================================================================
// Module      : arb_grant
// Description : Combinational winner select between ibus and dbus.
//               ARB_ROUND_ROBIN_EN selects alternating priority on
//               simultaneous requests; otherwise dbus always wins.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module arb_grant
    import mem_bus_arbiter_pkg::*;
(
    input  logic       ireq_valid,
    input  logic       dreq_valid,
    input  arb_owner_t pointer,
    output arb_owner_t owner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        owner = OWN_D;
        if (ireq_valid && dreq_valid) begin
            owner = pointer;
        end else if (ireq_valid) begin
            owner = OWN_I;
        end
    end
`else
    logic unused_pointer;
    assign unused_pointer = pointer;

    always_comb begin
        owner = (ireq_valid && !dreq_valid) ? OWN_I : OWN_D;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
//======================================================================
// Module      : mem_bus_arbiter
// Description : Serialises single-beat ibus/dbus transactions onto one
//               cbus port through an IDLE/BUSY/DONE FSM. Optional
//               round-robin arbitration via ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,
    output logic              creq_valid,
    output logic              creq_is_write,
    output logic [2:0]        creq_size,
    output logic [ADDR_W-1:0] creq_addr,
    output logic [7:0]        creq_strobe,
    output logic [DATA_W-1:0] creq_data,
    input  logic              cresp_ready,
    input  logic [DATA_W-1:0] cresp_data
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        winner;
    arb_owner_t        ptr;
    logic              valid_q, valid_d;
    logic              is_write_q, is_write_d;
    msize_t            size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              iok_q, iok_d;
    logic              dok_q, dok_d;
    logic              any_req;

    assign any_req = ireq_valid || dreq_valid;

    arb_grant u_arb_grant (
        .ireq_valid (ireq_valid),
        .dreq_valid (dreq_valid),
        .pointer    (ptr),
        .owner      (winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t ptr_q, ptr_d;

    // Priority passes to whichever requester was not just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && any_req) begin
            ptr_d = (winner == OWN_D) ? OWN_I : OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= OWN_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = OWN_D;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        valid_d    = 1'b0;
        is_write_d = is_write_q;
        size_d     = size_q;
        addr_d     = addr_q;
        strobe_d   = strobe_q;
        data_d     = data_q;
        cap_d      = cap_q;
        iok_d      = 1'b0;
        dok_d      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_BUSY;
                    owner_d = winner;
                    valid_d = 1'b1;
                    if (winner == OWN_D) begin
                        is_write_d = |dreq_strobe;
                        size_d     = msize_t'(dreq_size);
                        addr_d     = dreq_addr;
                        strobe_d   = dreq_strobe;
                        data_d     = dreq_data;
                    end else begin
                        is_write_d = 1'b0;
                        size_d     = MSIZE4;
                        addr_d     = ireq_addr;
                        strobe_d   = '0;
                        data_d     = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (cresp_ready) begin
                    state_d = ARB_DONE;
                    cap_d   = cresp_data;
                    iok_d   = (owner_q == OWN_I);
                    dok_d   = (owner_q == OWN_D);
                end else begin
                    valid_d = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_D;
            valid_q    <= 1'b0;
            is_write_q <= 1'b0;
            size_q     <= MSIZE1;
            addr_q     <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            iok_q      <= 1'b0;
            dok_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            valid_q    <= valid_d;
            is_write_q <= is_write_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            iok_q      <= iok_d;
            dok_q      <= dok_d;
        end
    end

    assign creq_valid    = valid_q;
    assign creq_is_write = is_write_q;
    assign creq_size     = size_q;
    assign creq_addr     = addr_q;
    assign creq_strobe   = strobe_q;
    assign creq_data     = data_q;
    assign iresp_addr_ok = iok_q;
    assign iresp_data_ok = iok_q;
    assign dresp_addr_ok = dok_q;
    assign dresp_data_ok = dok_q;
    assign dresp_data    = cap_q;
    assign iresp_data    = fetch_word(addr_q[2], cap_q[63:0]);

endmodule

`default_nettype wire
